// File: rtl/dffram_pkg.sv
// Shared types and helpers for the two-port behavioural DFFRAM.
// Holds the fill FSM states, the address-width helper and the byte-lane merge.
package dffram_pkg;

    typedef enum logic {
        FILL = 1'b0,
        IDLE = 1'b1
    } fill_state_t;

    // Merge is written once at a generous fixed width; callers zero-extend and slice.
    localparam int MAX_WIDTH = 1024;

    function automatic int a_width(input int cols);
        return 8 + $clog2(cols);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] merge(
        input logic [MAX_WIDTH-1:0]   old_word,
        input logic [MAX_WIDTH-1:0]   new_word,
        input logic [MAX_WIDTH/8-1:0] we
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_WIDTH/8; i++) begin
            if (we[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dffram_fill_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then parks in IDLE.
// BUSY is decoded from the state so it rises the moment reset is asserted.
module dffram_fill_seq
    import dffram_pkg::*;
#(
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               busy,
    output logic               fill_we,
    output logic [A_WIDTH-1:0] fill_addr
);

    fill_state_t        state, next_state;
    logic [A_WIDTH-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        fill_we    = 1'b0;
        case (state)
            FILL: begin
                busy     = 1'b1;
                fill_we  = 1'b1;
                cnt_next = cnt + 1'b1;
                // Depth is a power of two, so the last word is the all-ones address.
                if (&cnt) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = FILL;
            end
        endcase
    end

    assign fill_addr = cnt;

endmodule

// File: rtl/dffram_2p_beh.sv
// Behavioural 1W+1R word RAM with write-first bypass and post-reset zero fill.
// Define DFFRAM_OUT_REG_EN to add an output register stage (read latency 2).
module dffram_2p_beh
    import dffram_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int COLS    = 1,
    localparam int NB      = WIDTH / 8,
    localparam int A_WIDTH = a_width(COLS),
    localparam int DEPTH   = 1 << A_WIDTH
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               EN0,
    input  logic [NB-1:0]      WE0,
    input  logic [A_WIDTH-1:0] A0,
    input  logic [WIDTH-1:0]   Di0,
    input  logic               EN1,
    input  logic [A_WIDTH-1:0] A1,
    output logic [WIDTH-1:0]   Do1,
    output logic               BUSY
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 busy;
    logic                 fill_we;
    logic [A_WIDTH-1:0]   fill_addr;
    logic [MAX_WIDTH-1:0] merged_wide;
    logic                 unused_hi;
    logic [WIDTH-1:0]     wr_word;
    logic [WIDTH-1:0]     rd_word;
    logic                 rd_ok;

    dffram_fill_seq #(
        .A_WIDTH (A_WIDTH)
    ) u_fill (
        .clk       (CLK),
        .rst_n     (RESETn),
        .busy      (busy),
        .fill_we   (fill_we),
        .fill_addr (fill_addr)
    );

    assign BUSY = busy;

    assign merged_wide = merge(MAX_WIDTH'(mem[A0]), MAX_WIDTH'(Di0), (MAX_WIDTH/8)'(WE0));
    assign wr_word     = merged_wide[WIDTH-1:0];
    assign unused_hi   = ^merged_wide[MAX_WIDTH-1:WIDTH];

    // On a collision the merged write word is exactly the write-first read value.
    assign rd_word = (EN0 && (A0 == A1)) ? wr_word : mem[A1];
    assign rd_ok   = EN1 && !busy;

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            mem[fill_addr] <= '0;
        end else if (EN0) begin
            mem[A0] <= wr_word;
        end
    end

`ifdef DFFRAM_OUT_REG_EN
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    // stage 1: capture read/bypass data and its qualifier; stage 2: gate onto Do1
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            Do1     <= '0;
        end else begin
            data_p1 <= rd_word;
            vld_p1  <= rd_ok;
            Do1     <= vld_p1 ? data_p1 : '0;
        end
    end
`else
    // stage 1: read/bypass data straight onto Do1
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            Do1 <= '0;
        end else begin
            Do1 <= rd_ok ? rd_word : '0;
        end
    end
`endif

endmodule

// File: tb/tb_dffram_2p_beh.sv
// Self-checking bench for dffram_2p_beh: directed steps plus random traffic vs a word-array model.
// Honours DFFRAM_OUT_REG_EN for the expected read latency.
module tb_dffram_2p_beh;

`ifdef DFFRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 256;

    logic        CLK;
    logic        RESETn;
    logic        EN0;
    logic [3:0]  WE0;
    logic [7:0]  A0;
    logic [31:0] Di0;
    logic        EN1;
    logic [7:0]  A1;
    logic [31:0] Do1;
    logic        BUSY;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] pipe [LAT];
    int          fill_left;
    int          n_vec;
    int          n_err;
    int          cyc;

    dffram_2p_beh #(
        .WIDTH (32),
        .COLS  (1)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .EN0    (EN0),
        .WE0    (WE0),
        .A0     (A0),
        .Di0    (Di0),
        .EN1    (EN1),
        .A1     (A1),
        .Do1    (Do1),
        .BUSY   (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs held across the edge, then compare.
    task automatic tick();
        logic [31:0] rd;
        @(posedge CLK);
        #1;
        rd = '0;
        if (fill_left > 0) begin
            fill_left--;
        end else begin
            if (EN1) begin
                rd = ref_mem[A1];
                if (EN0 && (A0 == A1)) begin
                    for (int b = 0; b < 4; b++)
                        if (WE0[b]) rd[8*b +: 8] = Di0[8*b +: 8];
                end
            end
            if (EN0) begin
                for (int b = 0; b < 4; b++)
                    if (WE0[b]) ref_mem[A0][8*b +: 8] = Di0[8*b +: 8];
            end
        end
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = rd;
        chk32("do1", Do1, pipe[LAT-1]);
        chk1("busy", BUSY, fill_left > 0);
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        fill_left = DEPTH;
        chk32("rst_do1", Do1, 32'h0);
        chk1("rst_busy", BUSY, 1'b1);
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic count_fill(input string tag);
        cyc = 0;
        while (BUSY === 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk32(tag, 32'(cyc), 32'(DEPTH));
    endtask

    task automatic set_idle();
        EN0 = 1'b0;
        EN1 = 1'b0;
        WE0 = 4'h0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        EN0 = 1'b1; A0 = a; Di0 = d; WE0 = we; EN1 = 1'b0;
        tick();
        EN0 = 1'b0;
    endtask

    task automatic read_direct(input logic [7:0] a, input logic [31:0] exp, input string tag);
        EN0 = 1'b0; EN1 = 1'b1; A1 = a;
        tick();
        EN1 = 1'b0;
        repeat (LAT - 1) tick();
        chk32(tag, Do1, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RESETn = 1'b1;
        EN0 = 1'b0; WE0 = 4'h0; A0 = '0; Di0 = '0;
        EN1 = 1'b0; A1 = '0;
        #2;
        do_reset();
        count_fill("fill_len");
        read_direct(8'h00, 32'h0, "rd_00");
        read_direct(8'hFF, 32'h0, "rd_ff");

        write_word(8'h10, 32'hDEADBEEF, 4'b1111);
        write_word(8'h10, 32'h0000AA00, 4'b0010);
        read_direct(8'h10, 32'hDEADAAEF, "lane_merge");

        write_word(8'h20, 32'h11223344, 4'b1111);
        EN0 = 1'b1; A0 = 8'h20; Di0 = 32'hFFFFFFFF; WE0 = 4'b1001;
        EN1 = 1'b1; A1 = 8'h20;
        tick();
        set_idle();
        repeat (LAT - 1) tick();
        chk32("bypass", Do1, 32'hFF2233FF);
        read_direct(8'h20, 32'hFF2233FF, "bypass_ram");
        tick();
        chk32("en1_off", Do1, 32'h0);

        // Reset with traffic in flight, then hammer both ports through the fill.
        write_word(8'h30, 32'hCAFEF00D, 4'b1111);
        EN0 = 1'b1; A0 = 8'h31; Di0 = 32'h5A5A5A5A; WE0 = 4'hF;
        EN1 = 1'b1; A1 = 8'h30;
        do_reset();
        EN0 = 1'b1; A0 = 8'h10; Di0 = 32'h12345678; WE0 = 4'hF;
        EN1 = 1'b1; A1 = 8'h10;
        repeat (DEPTH / 2) tick();
        do_reset();
        count_fill("fill_len_restart");
        set_idle();
        read_direct(8'h30, 32'h0, "rst_cleared");
        read_direct(8'h10, 32'h0, "busy_wr_dropped");

        for (int a = 0; a < DEPTH; a++) begin
            EN0 = 1'b1; A0 = 8'(a); Di0 = $urandom; WE0 = 4'hF; EN1 = 1'b0;
            tick();
        end
        set_idle();
        for (int a = 0; a < DEPTH; a++) begin
            EN1 = 1'b1; A1 = 8'(a);
            tick();
        end
        set_idle();
        repeat (LAT) tick();

        // Narrow address range so collisions and partial-lane writes are frequent.
        for (int n = 0; n < 400; n++) begin
            EN0 = 1'($urandom_range(0, 1));
            EN1 = 1'($urandom_range(0, 1));
            WE0 = 4'($urandom_range(0, 15));
            A0  = 8'($urandom_range(0, 7));
            A1  = 8'($urandom_range(0, 7));
            Di0 = $urandom;
            tick();
        end
        set_idle();
        repeat (LAT) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
